// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: one-command-in-flight issue stage around an 8-bit,
// 16-mode combinational ALU with a small register file.
// Ports: clk, reset (async, active-high);
//   cmd_* valid/ready command in (op, dst, srca, srcb, imm_en, imm);
//   alu_a/alu_b/alu_mode to the ALU, alu_result/alu_cout from it;
//   res_* valid/ready response out (data, carry, zero, err);
//   rd_addr/rd_data combinational debug read of the register file.
module alu_issue_ctrl #(
    parameter int         NREG    = 4,
    parameter logic [7:0] RST_VAL = 8'h00,
    localparam int        AW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_srca,
    input  logic [AW-1:0] cmd_srcb,
    input  logic          cmd_imm_en,
    input  logic [7:0]    cmd_imm,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_mode,
    input  logic [7:0]    alu_result,
    input  logic          alu_cout,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_data,
    output logic          res_carry,
    output logic          res_zero,
    output logic          res_err,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] dst_q;
    logic [7:0]    rf [NREG];

    logic          div0;
    logic [7:0]    r_val;

    // alu_mode doubles as the latched opcode for the in-flight command.
    assign div0  = (alu_mode == 4'd3) && (alu_b == 8'h00);
    assign r_val = div0 ? 8'hFF : alu_result;

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign rd_data   = rf[rd_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            dst_q     <= '0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_mode  <= 4'h0;
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= RST_VAL;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dst_q    <= cmd_dst;
                        alu_a    <= rf[cmd_srca];
                        alu_b    <= cmd_imm_en ? cmd_imm
                                               : rf[cmd_srcb];
                        alu_mode <= cmd_op;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rf[dst_q] <= r_val;
                    res_data  <= r_val;
                    res_carry <= (alu_mode == 4'd0) && alu_cout;
                    res_zero  <= (r_val == 8'h00);
                    res_err   <= div0;
                    res_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
